// File: rtl/mul6_seq.sv
// 6x6 unsigned multiplier built from one shared 3x3 multiplier, four MUL steps.
// Latency: 4 edges from the accepting edge to out_valid; p is registered.
// Backpressure: p/out_valid hold in DONE until out_ready; in_ready only in IDLE.
module mul6_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  a,
  input  logic [5:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] p,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [5:0]  a_q, a_d;
  logic [5:0]  b_q, b_d;
  logic [11:0] acc_q, acc_d;
  logic [11:0] p_q, p_d;

  logic [2:0]  mul_x;
  logic [2:0]  mul_y;
  logic [5:0]  pp;
  logic [3:0]  pp_shamt;
  logic [11:0] pp_sh;
  logic        accept;

  // Select the operand slices for the current step and shift the partial product.
  // step[1] picks the high slice of a, step[0] the high slice of b.
  always_comb begin
    mul_x    = step_q[1] ? a_q[5:3] : a_q[2:0];
    mul_y    = step_q[0] ? b_q[5:3] : b_q[2:0];
    pp       = {3'b000, mul_x} * {3'b000, mul_y};
    pp_shamt = 4'd0;
    case (step_q)
      2'd0:    pp_shamt = 4'd0;
      2'd1:    pp_shamt = 4'd3;
      2'd2:    pp_shamt = 4'd3;
      default: pp_shamt = 4'd6;
    endcase
    pp_sh    = {6'b000000, pp} << pp_shamt;
  end

  // Handshake-facing outputs decoded from the registered state.
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    p         = p_q;
    accept    = in_valid && in_ready;
  end

  // Next-state and datapath updates; everything holds unless the state says otherwise.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = a;
          b_d     = b;
          acc_d   = 12'd0;
          step_d  = 2'd0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d  = acc_q + pp_sh;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          p_d     = acc_q + pp_sh;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight and clears the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      a_q     <= 6'd0;
      b_q     <= 6'd0;
      acc_q   <= 12'd0;
      p_q     <= 12'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end

endmodule

// File: tb/tb_mul6_seq.sv
// Directed and randomized checks of mul6_seq against plain a*b arithmetic.
module tb_mul6_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  a;
  logic [5:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] p;
  logic        busy;

  int n_assert;
  int n_fail;
  int n_out;
  int exp_q[$];

  mul6_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, wait out the multiply, stall, then hand off.
  task automatic do_op(input logic [5:0] ta, input logic [5:0] tb_, input int stall, input bit junk);
    int cnt;
    int exp_p;
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    a         = ta;
    b         = tb_;
    in_valid  = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    exp_q.push_back(int'(ta) * int'(tb_));
    @(negedge clk);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    chk("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    chk("out_valid_after_accept", {31'd0, out_valid}, 32'd0);
    if (!junk) in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      a         = 6'($urandom);
      b         = 6'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      cnt++;
      if (!out_valid && junk) begin
        chk("in_ready_low_in_mul", {31'd0, in_ready}, 32'd0);
        chk("busy_in_mul", {31'd0, busy}, 32'd1);
      end
    end
    chk("latency_edges", cnt, 32'd4);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("one_expected_pending", exp_q.size(), 32'd1);
    exp_p = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    chk("product", {20'd0, p}, exp_p);
    chk("busy_in_done", {31'd0, busy}, 32'd1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("out_valid_held", {31'd0, out_valid}, 32'd1);
      chk("p_held", {20'd0, p}, exp_p);
      chk("in_ready_low_in_done", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_out++;
    chk("out_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    chk("p_retained_idle", {20'd0, p}, exp_p);
  endtask

  initial begin
    int base;
    int idx;
    int cnt;
    n_assert  = 0;
    n_fail    = 0;
    n_out     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 6'd0;
    b         = 6'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_p", {20'd0, p}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Directed operand pairs
    do_op(6'd63, 6'd63, 0, 1'b0);
    do_op(6'd5,  6'd6,  0, 1'b0);
    do_op(6'd0,  6'd45, 1, 1'b0);
    do_op(6'd37, 6'd22, 3, 1'b0);
    do_op(6'd40, 6'd50, 2, 1'b1);

    // Reset in the middle of a multiply discards the operation
    @(negedge clk);
    a        = 6'd63;
    b        = 6'd1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("in_ready_during_rst", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_p_cleared", {20'd0, p}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("abort_no_out_valid", cnt, 32'd0);
    do_op(6'd9, 6'd7, 0, 1'b0);

    // Sweep every operand pair in a randomly offset order with random stalls
    base = int'($urandom_range(0, 4095));
    n_out = 0;
    for (int i = 0; i < 4096; i++) begin
      idx = (i * 2531 + base) % 4096;
      do_op(6'(idx / 64), 6'(idx % 64), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    chk("sweep_output_count", n_out, 32'd4096);
    chk("sweep_queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
